// File: rtl/req_encoder_seq.sv
// req_encoder_seq: latches request pulses into a pending vector and
// presents them one at a time as binary codes over a valid/ack handshake.
// Ports: clk, reset (async, active-high), enable (capture gate),
//   req[N] (request lines), ack (consumer accepts code),
//   code[W] (presented index), valid, pending[N] (pending vector).
module req_encoder_seq #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t       r_state;
  state_t       w_state_nx;
  logic [N-1:0] r_pending;
  logic [N-1:0] w_pending_nx;
  logic [N-1:0] w_onehot;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_rem;
  logic [N-1:0] w_src;
  logic [W-1:0] r_code;
  logic [W-1:0] w_code_nx;
  logic [W-1:0] w_pri;
  logic         w_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_code    <= w_code_nx;
      r_pending <= w_pending_nx;
    end
  end

  // rem excludes the presented bit; the priority search runs on the
  // whole pending vector in IDLE and on rem while presenting.
  always_comb begin
    w_fire   = (r_state == PRESENT) && ack;
    w_onehot = '0;
    w_onehot[r_code] = 1'b1;
    w_clr    = w_fire ? w_onehot : '0;
    w_rem    = r_pending & ~w_onehot;
    w_src    = (r_state == IDLE) ? r_pending : w_rem;
    // set wins over clear so a re-request on the ack edge survives
    w_pending_nx = (r_pending & ~w_clr) | (req & {N{enable}});
  end

  // lowest set bit wins: scan downward so the last hit is the lowest
  always_comb begin
    w_pri = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) w_pri = W'(i);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    unique case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_code_nx  = w_pri;
          w_state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          if (|w_rem) begin
            w_code_nx = w_pri;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign code    = r_code;
  assign valid   = (r_state == PRESENT);
  assign pending = r_pending;

endmodule

// File: tb/tb_req_encoder_seq.sv
// tb_req_encoder_seq: directed stimulus with a code scoreboard
// for req_encoder_seq.
module tb_req_encoder_seq;

  localparam int N = 8;
  localparam int W = 3;

  if (W != $clog2(N)) begin : g_bad_width
    $fatal(1, "FAIL width W=%0d N=%0d", W, N);
  end

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] code;
  logic         valid;
  logic [N-1:0] pending;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  req_encoder_seq #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; a handshake seen on that edge pops the scoreboard.
  task automatic tick();
    logic         fire;
    logic [W-1:0] c;
    fire = valid && ack;
    c    = code;
    @(posedge clk);
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(c), 32'hFFFF_FFFF);
      end else begin
        chk("sb_code", 32'(c), 32'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    req    = '0;
    ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    reset = 1'b0;

    // single event, ack held high
    enable = 1'b1;
    ack = 1'b1;
    req = 8'h20;
    exp_q.push_back(3'd5);
    tick();
    chk("s1_pend", 32'(pending), 32'h20);
    chk("s1_valid0", 32'(valid), 32'h0);
    req = 8'h00;
    tick();
    chk("s1_valid", 32'(valid), 32'h1);
    chk("s1_code", 32'(code), 32'h5);
    tick();
    chk("s1_done_v", 32'(valid), 32'h0);
    chk("s1_done_p", 32'(pending), 32'h00);

    // multi-hot priority, back-to-back
    req = 8'h94;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd7);
    tick();
    chk("m_pend", 32'(pending), 32'h94);
    req = 8'h00;
    tick();
    chk("m_code2", 32'(code), 32'h2);
    chk("m_v2", 32'(valid), 32'h1);
    tick();
    chk("m_code4", 32'(code), 32'h4);
    chk("m_v4", 32'(valid), 32'h1);
    chk("m_pend4", 32'(pending), 32'h90);
    tick();
    chk("m_code7", 32'(code), 32'h7);
    chk("m_v7", 32'(valid), 32'h1);
    tick();
    chk("m_done_v", 32'(valid), 32'h0);
    chk("m_done_p", 32'(pending), 32'h00);

    // stability under a higher-priority arrival
    ack = 1'b0;
    req = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    req = 8'h00;
    tick();
    chk("st_code", 32'(code), 32'h4);
    req = 8'h01;
    tick();
    chk("st_hold", 32'(code), 32'h4);
    chk("st_pend", 32'(pending), 32'h11);
    req = 8'h00;
    ack = 1'b1;
    exp_q.push_back(3'd0);
    tick();
    chk("st_next", 32'(code), 32'h0);
    chk("st_next_v", 32'(valid), 32'h1);
    tick();
    chk("st_done_v", 32'(valid), 32'h0);
    chk("st_done_p", 32'(pending), 32'h00);

    // same-bit set and clear on one edge
    ack = 1'b0;
    req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    req = 8'h00;
    tick();
    chk("c_code", 32'(code), 32'h3);
    ack = 1'b1;
    req = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    chk("c_bubble", 32'(valid), 32'h0);
    chk("c_pend", 32'(pending), 32'h08);
    req = 8'h00;
    tick();
    chk("c_re_v", 32'(valid), 32'h1);
    chk("c_re_code", 32'(code), 32'h3);
    tick();
    chk("c_done_v", 32'(valid), 32'h0);
    chk("c_done_p", 32'(pending), 32'h00);

    // gating, then async reset mid-presentation
    ack = 1'b0;
    req = 8'h04;
    tick();
    chk("g_pend", 32'(pending), 32'h04);
    enable = 1'b0;
    req = 8'hFF;
    tick();
    chk("g_gated", 32'(pending), 32'h04);
    chk("g_code", 32'(code), 32'h2);
    tick();
    chk("g_gated2", 32'(pending), 32'h04);
    chk("g_valid", 32'(valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(valid), 32'h0);
    chk("ar_code", 32'(code), 32'h0);
    chk("ar_pend", 32'(pending), 32'h00);
    req = 8'h00;
    enable = 1'b1;
    ack = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_valid", 32'(valid), 32'h0);
      chk("post_pend", 32'(pending), 32'h00);
    end
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder_seq.md
Name: req_encoder_seq

Overview:
- Sequential N-to-log2(N) encoder: the encode-side counterpart to the team's one-hot decoders.
- Latches one-hot or multi-hot request pulses into a pending register and presents them one at a time as binary codes.
- Presentation uses a valid/ack handshake; bit 0 has the highest priority.
- Used to turn per-line events (buttons, decoded strobes) into a binary index stream for downstream logic.

Parameters:
N, 8, number of request lines (power of two, >= 2)
W, 3, code width; must equal log2(N)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  when 1, req is sampled into pending; when 0, req is ignored
req  input  N  request lines; any bit high at a rising edge (with enable=1) sets the matching pending bit
ack  input  1  consumer accepts the current code; meaningful only while valid=1
code  output  W  binary index of the request being presented
valid  output  1  code is valid and held stable until acked
pending  output  N  registered pending-request vector, for visibility

Behaviour:
- Reset (async, active-high):
  - pending=0, code=0, valid=0, FSM=IDLE.
  - Takes effect immediately, independent of clk.
  - Reset mid-handshake discards every pending and presented request; no code is re-presented after reset releases.
- Pending update each rising edge:
  - pending_next = (pending & ~clr) | (req & {N{enable}}).
  - clr is the one-hot of code when valid&ack, else 0.
  - Same-bit set and clear in one cycle: set wins, so the re-request is kept as a new event.
  - Repeated req on an already-pending bit merges; there is no counting.
- Priority: the lowest-index set bit wins. pri(x) = index of the lowest set bit of x.
- FSM states: IDLE, PRESENT.
  - IDLE:
    - valid=0.
    - If the registered pending != 0 at an edge: code<=pri(pending), valid<=1, go to PRESENT.
    - Else stay in IDLE.
  - PRESENT:
    - valid=1; code is held stable while ack=0, even if a higher-priority request arrives.
    - On an edge with ack=1, let rem = pending & ~onehot(code).
      - If rem != 0: code<=pri(rem), valid stays 1, stay in PRESENT (back-to-back, no bubble).
      - If rem == 0: valid<=0, go to IDLE.
    - Requests arriving on the ack edge are not in rem. They are considered from the next edge, which costs one IDLE bubble cycle when rem == 0.
- Latency:
  - req high at edge k: pending bit visible after edge k.
  - valid/code asserted after edge k+1 when starting from IDLE, i.e. 2 cycles from req to valid.
- Throughput: one code per cycle while ack is held high and requests remain.
- Ignored inputs:
  - ack while valid=0 is ignored.
  - enable=0 only blocks new captures; existing pending bits and an in-progress presentation continue normally.
- Invariant: while valid=1, pending[code]=1. The presented bit is cleared only by its own ack.
- Arithmetic: code is always in the range 0..N-1; no wrap-around. Widths are fixed by the parameters; W != log2(N) is illegal, and the bench checks it with an elaboration assertion.

Test Plan:
- Reset with req=8'h00: pending=0, code=0, valid=0.
- Single event, ack held high: req=8'h20 for 1 cycle with enable=1.
  - pending=8'h20 after edge 1; valid=1, code=5 after edge 2.
  - Ack at edge 3: valid=0, pending=0.
- Multi-hot priority: req=8'h94 for 1 cycle, ack held high.
  - Codes 2, 4, 7 appear on consecutive cycles with no bubble.
  - Then valid=0 and pending=0.
- Stability: while code=4 is presented with ack=0, pulse req=8'h01.
  - code stays 4 and pending=8'h11.
  - After ack, code=0 on the next cycle.
- Same-bit collision: presenting code=3, assert ack and req=8'h08 on the same edge.
  - pending[3] stays 1; valid=0 for one IDLE cycle, then code=3 is re-presented.
- Gating and async reset:
  - enable=0 with req=8'hFF: pending unchanged.
  - Assert reset between clock edges while valid=1: valid, code and pending go to 0 immediately, not at the next edge.
  - After reset releases, no stale codes are presented.
